// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity of a data word: XOR reduction, inverted for odd parity.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_c
);

    assign o_par_c = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, data, optional parity, stop sequencing.
// Define UART_TX_STOP2_EN to add the i_stop2 port for an optional second stop bit.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
`ifdef UART_TX_STOP2_EN
    input  logic                  i_stop2,
`endif
    input  logic                  i_ser_data,
    input  logic                  i_ser_done,
    output logic [DATA_WIDTH-1:0] o_p_data,
    output logic                  o_ser_en,
    output logic                  o_tx_out,
    output logic                  o_busy,
    output logic                  o_sync_err
);

    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e               state_q,    state_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0]   p_data_q,   p_data_d;
    logic                    par_en_q,   par_en_d;
    logic                    par_bit_q,  par_bit_d;
    logic                    sync_err_q, sync_err_d;
    logic                    ser_en_q,   ser_en_d;
    logic                    busy_q,     busy_d;
`ifdef UART_TX_STOP2_EN
    logic                    stop2_q,    stop2_d;
    logic                    stop_cnt_q, stop_cnt_d;
`endif
    logic                    par_c;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .i_data    (i_data),
        .i_par_typ (i_par_typ),
        .o_par_c   (par_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_data_q   <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            sync_err_q <= 1'b0;
            ser_en_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_data_q   <= p_data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            sync_err_q <= sync_err_d;
            ser_en_q   <= ser_en_d;
            busy_q     <= busy_d;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_data_d   = p_data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        sync_err_d = sync_err_q;
`ifdef UART_TX_STOP2_EN
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_data_valid) begin
                    p_data_d  = i_data;
                    par_en_d  = i_par_en;
                    par_bit_d = par_c;
`ifdef UART_TX_STOP2_EN
                    stop2_d   = i_stop2;
`endif
                    state_d   = START;
                end
            end
            START: state_d = DATA;
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                // Serializer must flag its last bit exactly when our count does.
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                    if (!i_ser_done) begin
                        sync_err_d = 1'b1;
                    end
                end else if (i_ser_done) begin
                    sync_err_d = 1'b1;
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
`ifdef UART_TX_STOP2_EN
                if (stop2_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    stop_cnt_d = 1'b0;
                    state_d    = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        ser_en_d = (state_d == DATA);
        busy_d   = (state_d != IDLE);
    end

    // Line mux; data bits pass straight through from the serializer.
    always_comb begin
        o_tx_out = IDLE_BIT;
        case (state_q)
            IDLE:    o_tx_out = IDLE_BIT;
            START:   o_tx_out = START_BIT;
            DATA:    o_tx_out = i_ser_data;
            PARITY:  o_tx_out = par_bit_q;
            STOP:    o_tx_out = STOP_BIT;
            default: o_tx_out = IDLE_BIT;
        endcase
    end

    assign o_p_data   = p_data_q;
    assign o_ser_en   = ser_en_q;
    assign o_busy     = busy_q;
    assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a small serializer model driving i_ser_data/i_ser_done.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       i_par_en;
    logic       i_par_typ;
`ifdef UART_TX_STOP2_EN
    logic       i_stop2;
`endif
    logic       i_ser_data;
    logic       i_ser_done;
    logic [7:0] o_p_data;
    logic       o_ser_en;
    logic       o_tx_out;
    logic       o_busy;
    logic       o_sync_err;

    int n_vec = 0;
    int n_err = 0;

    // Serializer model: bench-owned byte, index advances on each enabled cycle.
    logic [7:0] ser_byte;
    logic [2:0] ser_idx;
    logic       done_kill;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_par_en     (i_par_en),
        .i_par_typ    (i_par_typ),
`ifdef UART_TX_STOP2_EN
        .i_stop2      (i_stop2),
`endif
        .i_ser_data   (i_ser_data),
        .i_ser_done   (i_ser_done),
        .o_p_data     (o_p_data),
        .o_ser_en     (o_ser_en),
        .o_tx_out     (o_tx_out),
        .o_busy       (o_busy),
        .o_sync_err   (o_sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (i_rst)         ser_idx <= 3'd0;
        else if (o_ser_en) ser_idx <= ser_idx + 3'd1;
    end

    assign i_ser_data = ser_byte[ser_idx];
    assign i_ser_done = o_ser_en && (ser_idx == 3'd7) && !done_kill;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a byte at the current negedge, then check every line bit plus the idle cycle after.
    // exp_line bit i is the expected line level in frame cycle i (start bit first).
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                             input logic [15:0] exp_line, input int len,
                             input logic hold, input logic [7:0] junk);
        int n_ser;
        n_ser        = 0;
        i_data       = d;
        i_data_valid = 1'b1;
        i_par_en     = pe;
        i_par_typ    = pt;
        ser_byte     = d;
        @(posedge clk);
        #1;
        i_data = junk;
        if (hold) begin
            i_par_en  = ~pe;
            i_par_typ = ~pt;
        end else begin
            i_data_valid = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s_line%0d", tag, i), 32'(o_tx_out), 32'(exp_line[i]));
            check_eq($sformatf("%s_busy%0d", tag, i), 32'(o_busy), 32'd1);
            if (i == 0) check_eq({tag, "_pdata"}, 32'(o_p_data), 32'(d));
            if (o_ser_en) n_ser++;
        end
        check_eq({tag, "_ser_en_cycles"}, 32'(n_ser), 32'd8);
        @(negedge clk);
        check_eq({tag, "_idle_line"}, 32'(o_tx_out), 32'd1);
        check_eq({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, "_idle_ser_en"}, 32'(o_ser_en), 32'd0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_data       = 8'h00;
        i_data_valid = 1'b0;
        i_par_en     = 1'b0;
        i_par_typ    = 1'b0;
`ifdef UART_TX_STOP2_EN
        i_stop2      = 1'b0;
`endif
        ser_byte     = 8'h00;
        done_kill    = 1'b0;

        // Reset, then idle with valid low.
        @(negedge clk);
        check_eq("rst_line", 32'(o_tx_out), 32'd1);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_ser_en", 32'(o_ser_en), 32'd0);
        check_eq("rst_sync_err", 32'(o_sync_err), 32'd0);
        check_eq("rst_pdata", 32'(o_p_data), 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_line", 32'(o_tx_out), 32'd1);
            check_eq("idle_busy", 32'(o_busy), 32'd0);
        end

        // {stop, parity, data, start}, sent start-first.
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0, 8'hFF);
        run_frame("07_odd",  8'h07, 1'b1, 1'b1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b0, 8'h00);
        run_frame("07_even", 8'h07, 1'b1, 1'b0, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1'b0, 8'h00);
        run_frame("5a_nopar", 8'h5A, 1'b0, 1'b1, 16'({1'b1, 8'h5A, 1'b0}), 10, 1'b0, 8'h00);
        check_eq("no_sync_err", 32'(o_sync_err), 32'd0);

        // Valid held high: second byte offered mid-frame must wait for one idle cycle.
        run_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 16'({1'b1, 8'h3C, 1'b0}), 10, 1'b1, 8'hC3);
        run_frame("b2b_c3", 8'hC3, 1'b0, 1'b0, 16'({1'b1, 8'hC3, 1'b0}), 10, 1'b0, 8'h00);
        @(negedge clk);
        check_eq("after_b2b_busy", 32'(o_busy), 32'd0);

        // Reset during the 4th data bit abandons the frame.
        i_data       = 8'hF0;
        i_data_valid = 1'b1;
        i_par_en     = 1'b0;
        ser_byte     = 8'hF0;
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_eq("mid_ser_en", 32'(o_ser_en), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_eq("mid_rst_line", 32'(o_tx_out), 32'd1);
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        check_eq("mid_rst_ser_en", 32'(o_ser_en), 32'd0);
        run_frame("55_after_rst", 8'h55, 1'b0, 1'b0, 16'({1'b1, 8'h55, 1'b0}), 10, 1'b0, 8'h00);
        check_eq("55_sync_err", 32'(o_sync_err), 32'd0);

        // Serializer never flags its last bit: sticky sync error.
        done_kill = 1'b1;
        run_frame("81_nodone", 8'h81, 1'b0, 1'b0, 16'({1'b1, 8'h81, 1'b0}), 10, 1'b0, 8'h00);
        check_eq("sync_err_set", 32'(o_sync_err), 32'd1);
        done_kill = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        run_frame("42_clean", 8'h42, 1'b1, 1'b1, 16'({1'b1, 1'b1, 8'h42, 1'b0}), 11, 1'b0, 8'h00);
        check_eq("sync_err_sticky", 32'(o_sync_err), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_eq("sync_err_rst", 32'(o_sync_err), 32'd0);

`ifdef UART_TX_STOP2_EN
        i_stop2 = 1'b1;
        run_frame("07_stop2", 8'h07, 1'b1, 1'b0, 16'({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}), 12, 1'b0, 8'h00);
        i_stop2 = 1'b0;
        run_frame("07_stop1", 8'h07, 1'b1, 1'b0, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1'b0, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
